gshare_btb_predictor: RTL

//  IF-stage next-PC generator for the 5-stage RV32I pipeline: PC register, gshare direction predictor, direct-mapped BTB.

---
 rtl/gshare_btb_predictor_pkg.sv | 25 ++
 rtl/gshare_btb_predictor_btb_table.sv | 46 ++++
 rtl/gshare_btb_predictor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gshare_btb_predictor_pkg.sv
// Shared types and helpers for the gshare/BTB fetch predictor.
package bp_pkg;

  typedef enum logic {INIT, RUN} bp_state_e;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned BHT_DEPTH_DEF = 64;
  localparam int unsigned BTB_DEPTH_DEF = 16;
  localparam int unsigned GHR_BITS_DEF  = 6;
  localparam int unsigned CTR_BITS_DEF  = 2;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic int unsigned ctr_weak_nt(input int unsigned bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int unsigned ctr_max(input int unsigned bits);
    return (1 << bits) - 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gshare_btb_predictor_btb_table.sv
// Direct-mapped branch target buffer: combinational read, synchronous write,
// and a per-entry clear used by the init walk.
module btb_table #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 26,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [XLEN-1:0]  rd_target_o,
  output logic             rd_jump_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [XLEN-1:0]  wr_target_i,
  input  logic             wr_jump_i,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] jump_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];

  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_tag_o    = tag_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];
  assign rd_jump_o   = jump_q[rd_idx_i];

  // Clear and write never overlap: clear only runs during INIT, writes only in RUN.
  always_ff @(posedge clk_i) begin
    if (clr_en_i) begin
      valid_q[clr_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i]  <= 1'b1;
      jump_q[wr_idx_i]   <= wr_jump_i;
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// IF-stage next-PC generator: PC register, gshare direction table, BTB,
// and an init walk that seeds the tables after reset.
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int unsigned    XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    BHT_DEPTH = BHT_DEPTH_DEF,
  parameter int unsigned    BTB_DEPTH = BTB_DEPTH_DEF,
  parameter int unsigned    GHR_BITS  = GHR_BITS_DEF,
  parameter int unsigned    CTR_BITS  = CTR_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_stall,
  input  logic                ex_redirect,
  input  logic [XLEN-1:0]     ex_redirect_pc,
  input  logic                upd_valid,
  input  logic [XLEN-1:0]     upd_pc,
  input  logic                upd_is_jump,
  input  logic                upd_taken,
  input  logic [XLEN-1:0]     upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  output logic [XLEN-1:0]     o_PC,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  output logic                init_busy
);

  localparam int unsigned BHT_IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W     = XLEN - BTB_IDX_W - 2;
  localparam int unsigned INIT_CNT  = max_u(BHT_DEPTH, BTB_DEPTH);
  localparam int unsigned INIT_W    = $clog2(INIT_CNT);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));

  bp_state_e           state_q;
  logic [INIT_W-1:0]   init_idx_q;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [GHR_BITS-1:0] ghr_q;
  logic [CTR_BITS-1:0] bht_q [BHT_DEPTH];

  logic                 run;
  logic [BHT_IDX_W-1:0] bidx, upd_bidx;
  logic [CTR_BITS-1:0]  ctr_cur, ctr_nxt;
  logic                 btb_valid, btb_jump;
  logic [TAG_W-1:0]     btb_tag;
  logic [XLEN-1:0]      btb_target;
  logic                 init_bht, init_btb, train_cond;

  assign run        = (state_q == RUN);
  assign init_bht   = !run && ({1'b0, init_idx_q} < (INIT_W + 1)'(BHT_DEPTH));
  assign init_btb   = !run && ({1'b0, init_idx_q} < (INIT_W + 1)'(BTB_DEPTH));
  assign train_cond = run && upd_valid && !upd_is_jump;

  assign bidx     = pc_q[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);
  assign upd_bidx = upd_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(upd_ghr);

  btb_table #(
    .XLEN (XLEN),
    .DEPTH(BTB_DEPTH),
    .TAG_W(TAG_W)
  ) u_btb (
    .clk_i      (clk),
    .rd_idx_i   (pc_q[BTB_IDX_W+1:2]),
    .rd_valid_o (btb_valid),
    .rd_tag_o   (btb_tag),
    .rd_target_o(btb_target),
    .rd_jump_o  (btb_jump),
    .wr_en_i    (run && upd_valid && upd_taken),
    .wr_idx_i   (upd_pc[BTB_IDX_W+1:2]),
    .wr_tag_i   (upd_pc[XLEN-1:BTB_IDX_W+2]),
    .wr_target_i(upd_target),
    .wr_jump_i  (upd_is_jump),
    .clr_en_i   (init_btb),
    .clr_idx_i  (init_idx_q[BTB_IDX_W-1:0])
  );

  assign pred_valid = run && btb_valid && (btb_tag == pc_q[XLEN-1:BTB_IDX_W+2]);
  assign pred_taken = pred_valid && (btb_jump || bht_q[bidx][CTR_BITS-1]);
  assign pred_ghr   = ghr_q;
  assign init_busy  = !run;
  assign o_PC       = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (run) begin
      if (ex_redirect)     pc_d = ex_redirect_pc;
      else if (pc_stall)   pc_d = pc_q;
      else if (pred_taken) pc_d = btb_target;
      else                 pc_d = pc_q + XLEN'(4);
    end
  end

  always_comb begin
    ctr_cur = bht_q[upd_bidx];
    ctr_nxt = ctr_cur;
    if (upd_taken && ctr_cur != CTR_MAX)      ctr_nxt = ctr_cur + CTR_BITS'(1);
    else if (!upd_taken && ctr_cur != '0)     ctr_nxt = ctr_cur - CTR_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      pc_q       <= RESET_PC;
      ghr_q      <= '0;
    end else begin
      pc_q <= pc_d;
      if (!run) begin
        if (init_idx_q == INIT_W'(INIT_CNT - 1)) state_q <= RUN;
        init_idx_q <= init_idx_q + INIT_W'(1);
      end else if (train_cond) begin
        // History is non-speculative: only resolved conditional branches shift in.
        ghr_q <= {ghr_q[GHR_BITS-2:0], upd_taken};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_bht)        bht_q[init_idx_q[BHT_IDX_W-1:0]] <= CTR_WNT;
      else if (train_cond) bht_q[upd_bidx] <= ctr_nxt;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{pc_q[1:0], upd_pc[1:0]};

endmodule
